// File: rtl/axi_lite_times_table_slave_if.sv
// AXI4-Lite bus bundle used between a master and the times-table slave.
// clk and rst are kept as plain module ports; only the channel signals live here.
interface axi_lite_times_table_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // write address channel
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  // write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  // write response channel
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // read address channel
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  // read data channel
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_times_table_slave.sv
// AXI4-Lite slave holding a 2^(2*OPERAND_W)-entry times table.
// Word index is {a,b} taken straight from the low address bits; each entry
// resets to a*b and can be overwritten byte-wise through the write channel.
// Read and write paths are separate FSMs with fully registered outputs.
module axi_lite_times_table_slave #(
  parameter int OPERAND_W = 3,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  axi_lite_times_table_slave_if.slave s_axi
);

  localparam int IDX_W  = 2 * OPERAND_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'b00,
    W_GOT_AW = 2'b01,
    W_GOT_W  = 2'b10,
    W_RESP   = 2'b11
  } w_state_e;

  // Reset content of one table entry: upper operand times lower operand.
  function automatic logic [DATA_W-1:0] init_entry(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] a_v;
    logic [DATA_W-1:0] b_v;
    a_v = DATA_W'(idx[IDX_W-1:OPERAND_W]);
    b_v = DATA_W'(idx[OPERAND_W-1:0]);
    return a_v * b_v;
  endfunction

  // Byte address is used directly as the word index; anything above it must be zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:IDX_W] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [1:0]        rresp_q,   rresp_d;

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  w_state_e          w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic              wready_q,  wready_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;
  logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0] wstrb_q,   wstrb_d;

  logic              aw_hs_s;
  logic              w_hs_s;
  logic              commit_s;
  logic [ADDR_W-1:0] commit_addr_s;
  logic [DATA_W-1:0] commit_data_s;
  logic [STRB_W-1:0] commit_strb_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  commit_idx_s;

  assign aw_hs_s      = s_axi.awvalid & awready_q;
  assign w_hs_s       = s_axi.wvalid & wready_q;
  assign mem_we_s     = commit_s & addr_in_range(commit_addr_s);
  assign commit_idx_s = addr_index(commit_addr_s);

  // Read FSM next state: sample the table on the AR handshake, hold until rready.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          r_state_d = R_VALID;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          if (addr_in_range(s_axi.araddr)) begin
            // mem_q is pre-commit here, so a same-cycle write is not visible
            rdata_d = mem_q[addr_index(s_axi.araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_VALID: begin
        if (s_axi.rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end else begin
          r_state_d = R_VALID;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
      end
    endcase
  end

  // Read FSM registers with registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write FSM next state: collect AW and W in any order, commit when both are in.
  always_comb begin
    w_state_d     = w_state_q;
    awready_d     = awready_q;
    wready_d      = wready_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    commit_s      = 1'b0;
    commit_addr_s = awaddr_q;
    commit_data_s = wdata_q;
    commit_strb_s = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s      = 1'b1;
          commit_addr_s = s_axi.awaddr;
          commit_data_s = s_axi.wdata;
          commit_strb_s = s_axi.wstrb;
        end else if (aw_hs_s) begin
          awaddr_d  = s_axi.awaddr;
          awready_d = 1'b0;
          w_state_d = W_GOT_AW;
        end else if (w_hs_s) begin
          wdata_d   = s_axi.wdata;
          wstrb_d   = s_axi.wstrb;
          wready_d  = 1'b0;
          w_state_d = W_GOT_W;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_GOT_AW: begin
        if (w_hs_s) begin
          commit_s      = 1'b1;
          commit_addr_s = awaddr_q;
          commit_data_s = s_axi.wdata;
          commit_strb_s = s_axi.wstrb;
        end else begin
          w_state_d = W_GOT_AW;
        end
      end
      W_GOT_W: begin
        if (aw_hs_s) begin
          commit_s      = 1'b1;
          commit_addr_s = s_axi.awaddr;
          commit_data_s = wdata_q;
          commit_strb_s = wstrb_q;
        end else begin
          w_state_d = W_GOT_W;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
      end
    endcase

    if (commit_s) begin
      w_state_d = W_RESP;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = addr_in_range(commit_addr_s) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      bresp_d = bresp_d;
    end
  end

  // Write FSM registers with registered bus outputs and latched AW/W halves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Table storage: restored to a*b on reset, byte-enabled update on an in-range commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_entry(IDX_W'(i));
      end
    end else if (mem_we_s) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (commit_strb_s[k]) begin
          mem_q[commit_idx_s][8*k +: 8] <= commit_data_s[8*k +: 8];
        end
      end
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_times_table_slave.sv
// Directed + randomized bench for the AXI4-Lite times-table slave.
// Reference model: a plain 64-word array initialised with a*b and updated
// byte-wise on in-range writes.
module tb_axi_lite_times_table_slave;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_lite_times_table_slave_if bus ();

  axi_lite_times_table_slave dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  logic [31:0] ref_mem [64];

  function automatic void ref_reset();
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'((i / 8) * (i % 8));
    end
  endfunction

  function automatic void ref_read(input logic [31:0] addr, output logic [31:0] data,
                                   output logic [1:0] resp);
    if (addr < 32'd64) begin
      data = ref_mem[addr[5:0]];
      resp = 2'b00;
    end else begin
      data = 32'd0;
      resp = 2'b10;
    end
  endfunction

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, output logic [1:0] resp);
    if (addr < 32'd64) begin
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) ref_mem[addr[5:0]][8*k +: 8] = data[8*k +: 8];
      end
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full read transaction starting at a negedge; rready held low for rdly cycles.
  task automatic do_read(input logic [31:0] addr, input int rdly, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    int          cyc;
    ref_read(addr, ed, er);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    cyc = 0;
    while (!bus.arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ar_wait"}, 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check({tag, "_rdata"}, bus.rdata, ed);
    check({tag, "_rresp"}, 32'(bus.rresp), 32'(er));
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      check({tag, "_rdata_hold"}, bus.rdata, ed);
      check({tag, "_arready_hold"}, 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check({tag, "_rvalid_drop"}, 32'(bus.rvalid), 32'd0);
  endtask

  // Full write transaction starting at a negedge; AW/W offered after awd/wd cycles.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awd, input int wd,
                          input int bdly, input string tag);
    logic [1:0] er;
    logic       aw_pend;
    logic       w_pend;
    logic       aw_fire;
    logic       w_fire;
    int         cyc;
    ref_write(addr, data, strb, er);
    aw_pend    = 1'b1;
    w_pend     = 1'b1;
    cyc        = 0;
    bus.bready = 1'b0;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    while ((aw_pend || w_pend) && cyc < 30) begin
      bus.awvalid = aw_pend && (cyc >= awd);
      bus.wvalid  = w_pend && (cyc >= wd);
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(negedge clk);
      cyc++;
      if (aw_fire) aw_pend = 1'b0;
      if (w_fire)  w_pend  = 1'b0;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check({tag, "_hs_wait"}, 32'(aw_pend || w_pend), 32'd0);
    check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bus.bresp), 32'(er));
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      check({tag, "_bvalid_hold"}, 32'(bus.bvalid), 32'd1);
      check({tag, "_awready_resp"}, 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check({tag, "_bvalid_drop"}, 32'(bus.bvalid), 32'd0);
    check({tag, "_ready_back"}, 32'({bus.awready, bus.wready}), 32'd3);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  er;

    rst         = 1'b0;
    bus.awaddr  = 32'd0;
    bus.awvalid = 1'b0;
    bus.wdata   = 32'd0;
    bus.wstrb   = 4'd0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = 32'd0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    ref_reset();

    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_resps", 32'({bus.rresp, bus.bresp}), 32'd0);
    check("rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);
    rst = 1'b1;
    @(negedge clk);

    // basic reads
    do_read(32'h0000_003F, 0, "rd_3f");
    do_read(32'h0000_0000, 0, "rd_00");

    // streamed reads: arvalid held, rready held, one read every two cycles
    bus.rready  = 1'b1;
    bus.arvalid = 1'b1;
    bus.araddr  = 32'd0;
    for (int i = 0; i < 64; i++) begin
      check("stream_arready_hi", 32'(bus.arready), 32'd1);
      @(negedge clk);
      check("stream_arready_lo", 32'(bus.arready), 32'd0);
      check("stream_rvalid", 32'(bus.rvalid), 32'd1);
      check("stream_rdata", bus.rdata, 32'((i / 8) * (i % 8)));
      bus.araddr  = 32'(i + 1);
      bus.arvalid = (i < 63);
      @(negedge clk);
    end
    bus.rready = 1'b0;
    check("stream_end_rvalid", 32'(bus.rvalid), 32'd0);

    // W two cycles ahead of AW to 0x0A, low byte only
    bus.wdata  = 32'hDEAD_BEFF;
    bus.wstrb  = 4'b0001;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("wfirst_wready_lo", 32'(bus.wready), 32'd0);
    check("wfirst_awready_hi", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awaddr  = 32'h0000_000A;
    bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    ref_write(32'h0000_000A, 32'hDEAD_BEFF, 4'b0001, er);
    check("wfirst_bvalid", 32'(bus.bvalid), 32'd1);
    check("wfirst_bresp", 32'(bus.bresp), 32'(er));
    @(negedge clk);
    check("wfirst_bvalid_hold", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("wfirst_bvalid_drop", 32'(bus.bvalid), 32'd0);
    do_read(32'h0000_000A, 0, "rd_0a");
    check("wfirst_model", ref_mem[10], 32'h0000_00FF);

    // read to 0x15 stalled by rready, write to 0x15 in the same cycle
    bus.araddr  = 32'h0000_0015;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    bus.awaddr  = 32'h0000_0015;
    bus.wdata   = 32'h1234_5678;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    ref_write(32'h0000_0015, 32'h1234_5678, 4'hF, er);
    check("coll_rvalid", 32'(bus.rvalid), 32'd1);
    check("coll_rdata_old", bus.rdata, 32'h0000_000A);
    check("coll_arready", 32'(bus.arready), 32'd0);
    check("coll_bvalid", 32'(bus.bvalid), 32'd1);
    check("coll_bresp", 32'(bus.bresp), 32'(er));
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("coll_bvalid_drop", 32'(bus.bvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("coll_stall_rvalid", 32'(bus.rvalid), 32'd1);
      check("coll_stall_rdata", bus.rdata, 32'h0000_000A);
      check("coll_stall_arready", 32'(bus.arready), 32'd0);
      @(negedge clk);
    end
    check("coll_stall_rdata_end", bus.rdata, 32'h0000_000A);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("coll_rvalid_drop", 32'(bus.rvalid), 32'd0);
    do_read(32'h0000_0015, 0, "rd_15_new");

    // out-of-range accesses
    do_read(32'h0000_0040, 1, "rd_oor_40");
    do_write(32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_oor_100");
    do_read(32'h0000_0000, 0, "rd_00_after_oor");

    // zero-strobe write leaves the entry alone
    do_write(32'h0000_0009, 32'hFFFF_FFFF, 4'h0, 1, 0, 1, "wr_nostrb");
    do_read(32'h0000_0009, 0, "rd_09_nostrb");

    // randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 1023)) << 6);
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        do_write(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), "rnd_wr");
        do_read(addr, $urandom_range(0, 2), "rnd_rd_back");
      end else begin
        do_read(addr, $urandom_range(0, 2), "rnd_rd");
      end
    end

    // overwrite 0x3F, then reset in the middle of a read
    do_write(32'h0000_003F, 32'h0000_0055, 4'hF, 0, 0, 0, "wr_3f");
    bus.araddr  = 32'h0000_003F;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
    check("pre_rst_rdata", bus.rdata, 32'h0000_0055);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("mid_rst_arready", 32'(bus.arready), 32'd1);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    ref_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(32'h0000_003F, 0, "rd_3f_after_rst");
    do_read(32'h0000_0015, 0, "rd_15_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
